// File: rtl/output_readout_scheduler.sv
// Output readout scheduler: reads one row from every output BRAM at once,
// buffers it, then streams the row word by word over an AXI-Stream master.
module output_readout_scheduler #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH:0]             num_rows,
    input  logic                            abort,
    output logic                            ext_read_mode,
    output logic [NUM_BRAMS-1:0]            ext_read_en,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
    input  logic [NUM_BRAMS*DW-1:0]         bram_read_data_flat,
    output logic [DW-1:0]                   m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            done
);

    localparam int WW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
    localparam logic [WW-1:0]       WLast   = WW'(NUM_BRAMS - 1);
    localparam logic [ADDR_WIDTH:0] RowsMax = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StStream, StFinish} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] r_q;
    logic [ADDR_WIDTH:0]   rows_q;
    logic [WW-1:0]         w_q;
    logic [DW-1:0]         row_q [NUM_BRAMS];

    logic last_row;
    logic last_word;
    logic hs;

    assign last_row  = ({1'b0, r_q} == (rows_q - (ADDR_WIDTH + 1)'(1)));
    assign last_word = (w_q == WLast);
    assign hs        = (state_q == StStream) && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            rows_q  <= '0;
            w_q     <= '0;
            for (int k = 0; k < NUM_BRAMS; k++) begin
                row_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        r_q     <= '0;
                        w_q     <= '0;
                        rows_q  <= (num_rows > RowsMax) ? RowsMax : num_rows;
                        state_q <= (num_rows == '0) ? StFinish : StRead;
                    end
                end
                StRead: begin
                    state_q <= abort ? StFinish : StCapture;
                end
                StCapture: begin
                    for (int k = 0; k < NUM_BRAMS; k++) begin
                        row_q[k] <= bram_read_data_flat[k*DW +: DW];
                    end
                    state_q <= abort ? StFinish : StStream;
                end
                StStream: begin
                    // A handshake in the abort cycle still counts; abort only steers the state.
                    if (hs) begin
                        if (last_word) begin
                            w_q <= '0;
                            if (!last_row) begin
                                r_q <= r_q + ADDR_WIDTH'(1);
                            end
                        end else begin
                            w_q <= w_q + WW'(1);
                        end
                    end
                    if (abort) begin
                        state_q <= StFinish;
                    end else if (hs && last_word) begin
                        state_q <= last_row ? StFinish : StRead;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode flops only, so no input reaches an output combinationally.
    assign ext_read_mode      = (state_q == StRead) || (state_q == StCapture) ||
                                (state_q == StStream);
    assign ext_read_en        = {NUM_BRAMS{state_q == StRead}};
    assign ext_read_addr_flat = {NUM_BRAMS{r_q}};
    assign m_axis_tvalid      = (state_q == StStream);
    assign m_axis_tdata       = m_axis_tvalid ? row_q[w_q] : '0;
    assign m_axis_tlast       = m_axis_tvalid && last_word && last_row;
    assign busy               = (state_q != StIdle);
    assign done               = (state_q == StFinish);

endmodule
